// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding, data width,
// and the clocks-per-bit divisor helper.
`timescale 1ns/1ps
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [2:0] {
    UART_IDLE  = 3'd0,
    UART_START = 3'd1,
    UART_DATA  = 3'd2,
    UART_STOP  = 3'd3,
    UART_BREAK = 3'd4
  } uart_state_e;

  // Integer divide: rounding error is bounded to under one clock per bit.
  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_sync.sv
// Multi-bit 2-flop synchronizer for asynchronous inputs.
// Each bit is synchronized independently; RST_VAL sets the value both flops
// take during reset (idle-high lines use all ones).
`timescale 1ns/1ps
module uart_sync #(
  parameter int           W       = 1,
  parameter logic [W-1:0] RST_VAL = '1
) (
  input  logic         clk,
  input  logic         nRst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta_reg;
  logic [W-1:0] sync_reg;

  for (genvar gi = 0; gi < W; gi++) begin : g_bit
    // Two back-to-back flops per bit to resolve metastability.
    always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
        meta_reg[gi] <= RST_VAL[gi];
        sync_reg[gi] <= RST_VAL[gi];
      end else begin
        meta_reg[gi] <= d[gi];
        sync_reg[gi] <= meta_reg[gi];
      end
    end
  end

  assign q = sync_reg;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver. Recovers bytes from the asynchronous rx pin and emits a
// one-cycle valid strobe with data, or a one-cycle frame_err strobe when the
// stop bit is low. A held-low line after a framing error parks in BREAK until
// the line goes high again.
// Optional build macro: UART_RX_MAJORITY_EN -- each sample becomes the 2-of-3
// majority of the synchronized line at sample point -2, -1 and 0 cycles.
`timescale 1ns/1ps
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_HZ       = 50_000_000,
  parameter int BAUD         = 115200,
  parameter int CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD)
) (
  input  logic                   clk,
  input  logic                   nRst,
  input  logic                   rx,
  output logic [UART_DATA_W-1:0] data,
  output logic                   valid,
  output logic                   frame_err,
  output logic                   busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  // Start-bit centre is half a bit after T0; later centres are a full bit apart.
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

  localparam logic [2:0] IDLE  = UART_IDLE;
  localparam logic [2:0] START = UART_START;
  localparam logic [2:0] DATA  = UART_DATA;
  localparam logic [2:0] STOP  = UART_STOP;
  localparam logic [2:0] BREAK = UART_BREAK;

  logic                   rx_s;
  logic                   samp;
  logic [2:0]             state_reg;
  logic [CNT_W-1:0]       cnt_reg;
  logic [2:0]             bit_idx_reg;
  logic [UART_DATA_W-1:0] shift_reg;
  logic [UART_DATA_W-1:0] data_reg;
  logic                   valid_reg;
  logic                   frame_err_reg;

  uart_sync #(
    .W       (1),
    .RST_VAL (1'b1)
  ) u_sync (
    .clk  (clk),
    .nRst (nRst),
    .d    (rx),
    .q    (rx_s)
  );

`ifdef UART_RX_MAJORITY_EN
  // hist_reg[0] is rx_s one cycle back, hist_reg[1] two cycles back.
  logic [1:0] hist_reg;

  // Short line history feeding the 2-of-3 vote.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) hist_reg <= 2'b11;
    else       hist_reg <= {hist_reg[0], rx_s};
  end

  assign samp = (rx_s & hist_reg[0]) | (rx_s & hist_reg[1]) | (hist_reg[0] & hist_reg[1]);
`else
  assign samp = rx_s;
`endif

  // Frame FSM: bit timing, shift-in, output strobes and the data register.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      bit_idx_reg   <= '0;
      shift_reg     <= '0;
      data_reg      <= '0;
      valid_reg     <= 1'b0;
      frame_err_reg <= 1'b0;
    end else begin
      valid_reg     <= 1'b0;
      frame_err_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (!rx_s) begin
            state_reg <= START;
            cnt_reg   <= '0;
          end
        end
        START: begin
          if (cnt_reg == HALF_M1) begin
            cnt_reg <= '0;
            if (!samp) begin
              state_reg   <= DATA;
              bit_idx_reg <= '0;
            end else begin
              state_reg <= IDLE;   // glitch shorter than half a bit
            end
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        DATA: begin
          if (cnt_reg == FULL_M1) begin
            cnt_reg   <= '0;
            shift_reg <= {samp, shift_reg[UART_DATA_W-1:1]};
            if (bit_idx_reg == 3'd7) state_reg <= STOP;
            else                     bit_idx_reg <= bit_idx_reg + 3'd1;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        STOP: begin
          // Leaving at mid-stop-bit lets a zero-gap next start bit be caught.
          if (cnt_reg == FULL_M1) begin
            cnt_reg <= '0;
            if (samp) begin
              data_reg  <= shift_reg;
              valid_reg <= 1'b1;
              state_reg <= IDLE;
            end else begin
              frame_err_reg <= 1'b1;
              state_reg     <= BREAK;
            end
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        BREAK: begin
          if (rx_s) state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign data      = data_reg;
  assign valid     = valid_reg;
  assign frame_err = frame_err_reg;
  assign busy      = (state_reg != IDLE);

endmodule
